// File: rtl/sop_pkg.sv
// sop_pkg
//   Shared definitions for the programmable sum-of-products evaluator:
//   FSM state encoding, default input width, the legacy minterm mask and a
//   depth helper.
package sop_pkg;

    // FSM states of the truth-table walker.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } sop_state_e;

    // Default number of function inputs.
    localparam int SOP_N_IN_DEFAULT = 3;

    // Largest supported number of inputs and the matching table depth.
    localparam int SOP_N_IN_MAX  = 8;
    localparam int SOP_MAX_DEPTH = 256;

    // Minterms 0, 2, 4 and 5: the function of the fixed legacy gate.
    localparam logic [7:0] SOP_LEGACY_MASK = 8'h35;

    // Number of minterms of an n-input function.
    function automatic int sop_depth(input int n);
        return 32'sd1 << n;
    endfunction

endpackage : sop_pkg

// File: rtl/sop_lut_eval.sv
// sop_lut_eval
//   Minterm mask register with two independent read ports.
//   Ports:
//     clk        - clock, rising edge
//     rst        - synchronous active-high reset, loads RESET_MASK
//     we_i       - load wdata_i into the mask
//     wdata_i    - new minterm mask (DEPTH bits)
//     raddr_a_i  - read address A (direct-mode input vector)
//     raddr_b_i  - read address B (sweep index)
//     rdata_a_o  - mask bit at raddr_a_i (pre-write value on a write edge)
//     rdata_b_o  - mask bit at raddr_b_i
module sop_lut_eval
    import sop_pkg::*;
#(
    parameter int                         N_IN       = SOP_N_IN_DEFAULT,
    parameter int                         DEPTH      = sop_depth(N_IN),
    parameter logic [SOP_MAX_DEPTH-1:0]   RESET_MASK = SOP_MAX_DEPTH'(SOP_LEGACY_MASK)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [DEPTH-1:0]  wdata_i,
    input  logic [N_IN-1:0]   raddr_a_i,
    input  logic [N_IN-1:0]   raddr_b_i,
    output logic              rdata_a_o,
    output logic              rdata_b_o
);

    logic [DEPTH-1:0] mask_q;
    logic [DEPTH-1:0] mask_d;

    // Next mask value: take the write data when enabled.
    always_comb begin
        mask_d = mask_q;
        if (we_i) begin
            mask_d = wdata_i;
        end else begin
            mask_d = mask_q;
        end
    end

    // Mask register.
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q <= RESET_MASK[DEPTH-1:0];
        end else begin
            mask_q <= mask_d;
        end
    end

    // Both read ports see the registered mask, so a same-edge write is not visible yet.
    assign rdata_a_o = mask_q[raddr_a_i];
    assign rdata_b_o = mask_q[raddr_b_i];

endmodule : sop_lut_eval

// File: rtl/sop_lut_sweeper.sv
// sop_lut_sweeper
//   Programmable N_IN-input sum-of-products evaluator. Direct mode registers
//   F(in_vec) every cycle; sweep mode walks the whole truth table, streaming
//   (index, F) beats over valid/ready and counting accepted ones.
//   Optional feature: define SOP_ABORT_EN to add the 'abort' input, which
//   returns a running sweep to IDLE without a done pulse.
//   Ports:
//     clk, rst             - clock and synchronous active-high reset
//     cfg_we, cfg_mask     - mask load (accepted in IDLE and DONE only)
//     in_vec, f_q          - direct-mode input and registered result
//     start, busy          - sweep launch and FSM-not-idle flag
//     out_valid, out_ready - sweep beat handshake
//     out_idx, out_f       - minterm index and its mask bit
//     done                 - one-cycle pulse at sweep completion
//     ones_count           - accepted beats with out_f=1 in the last/current sweep
//     abort                - (SOP_ABORT_EN only) cancel a running sweep
module sop_lut_sweeper
    import sop_pkg::*;
#(
    parameter int                         N_IN       = SOP_N_IN_DEFAULT,
    parameter logic [SOP_MAX_DEPTH-1:0]   RESET_MASK = SOP_MAX_DEPTH'(SOP_LEGACY_MASK)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_we,
    input  logic [sop_depth(N_IN)-1:0]    cfg_mask,
    input  logic [N_IN-1:0]               in_vec,
    output logic                          f_q,
    input  logic                          start,
`ifdef SOP_ABORT_EN
    input  logic                          abort,
`endif
    output logic                          busy,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [N_IN-1:0]               out_idx,
    output logic                          out_f,
    output logic                          done,
    output logic [N_IN:0]                 ones_count
);

    localparam int              DEPTH    = sop_depth(N_IN);
    localparam logic [N_IN-1:0] IDX_LAST = N_IN'(DEPTH - 1);

    sop_state_e       state_q;
    sop_state_e       state_d;
    logic [N_IN-1:0]  idx_q;
    logic [N_IN-1:0]  idx_d;
    logic [N_IN:0]    cnt_q;
    logic [N_IN:0]    cnt_d;
    logic             f_d;

    logic             mask_we_s;
    logic             lut_a_s;
    logic             lut_b_s;
    logic             in_sweep_s;
    logic             beat_s;
    logic             abort_s;

`ifdef SOP_ABORT_EN
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    // The mask is frozen while a sweep is running.
    assign mask_we_s  = cfg_we && ((state_q == IDLE) || (state_q == DONE));
    assign in_sweep_s = (state_q == SWEEP);
    assign beat_s     = in_sweep_s && out_ready;

    sop_lut_eval #(
        .N_IN       (N_IN),
        .DEPTH      (DEPTH),
        .RESET_MASK (RESET_MASK)
    ) u_lut (
        .clk       (clk),
        .rst       (rst),
        .we_i      (mask_we_s),
        .wdata_i   (cfg_mask),
        .raddr_a_i (in_vec),
        .raddr_b_i (idx_q),
        .rdata_a_o (lut_a_s),
        .rdata_b_o (lut_b_s)
    );

    // Next-state logic for the sweep FSM, index and ones counter.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        f_d     = lut_a_s;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SWEEP;
                    idx_d   = {N_IN{1'b0}};
                    cnt_d   = {(N_IN+1){1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            SWEEP: begin
                // A beat accepted on the abort edge still counts.
                if (beat_s) begin
                    cnt_d = cnt_q + (N_IN+1)'(lut_b_s);
                end else begin
                    cnt_d = cnt_q;
                end
                if (abort_s) begin
                    state_d = IDLE;
                    idx_d   = {N_IN{1'b0}};
                end else if (beat_s) begin
                    // Terminal beat ends the sweep; idx never wraps.
                    if (idx_q == IDX_LAST) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + N_IN'(1);
                    end
                end else begin
                    state_d = SWEEP;
                end
            end
            DONE: begin
                state_d = IDLE;
                idx_d   = {N_IN{1'b0}};
            end
            default: begin
                state_d = IDLE;
                idx_d   = {N_IN{1'b0}};
            end
        endcase
    end

    // State, index, counter and direct-mode result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= {N_IN{1'b0}};
            cnt_q   <= {(N_IN+1){1'b0}};
            f_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            f_q     <= f_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign out_valid  = in_sweep_s;
    assign out_idx    = in_sweep_s ? idx_q : {N_IN{1'b0}};
    assign out_f      = in_sweep_s ? lut_b_s : 1'b0;
    assign done       = (state_q == DONE);
    assign ones_count = cnt_q;

endmodule : sop_lut_sweeper

// File: doc/sop_lut_sweeper.md
Name: sop_lut_sweeper

Overview:
- Parametrised, programmable sum-of-products evaluator. Successor to the fixed 3-input SoP gate.
- The function of N_IN inputs is held as a 2^N_IN-bit minterm mask register (bit k set means minterm k is in the SoP).
- Two modes:
  - Direct mode: registers F for the live input vector every cycle.
  - Sweep mode: a hardware truth-table walker that streams (index, F) pairs over a valid/ready handshake and counts ones.
- Sits beside the combinational logic blocks as a self-checking, reconfigurable replacement.

Parameters:
- N_IN, 3, number of function inputs (1..8); DEPTH = 2^N_IN.
- RESET_MASK, 'h35, mask loaded on reset. 'h35 sets minterms 0, 2, 4, 5, matching the legacy SoP function. Only the low DEPTH bits are used.

Ports:
- clk, input, 1, system clock, rising edge.
- rst, input, 1, synchronous active-high reset.
- cfg_we, input, 1, load cfg_mask into the mask register.
- cfg_mask, input, DEPTH, new minterm mask.
- in_vec, input, N_IN, direct-mode input vector; MSB is the first variable (A).
- f_q, output, 1, registered direct-mode result.
- start, input, 1, begin a sweep.
- busy, output, 1, high while the FSM is not in IDLE.
- out_valid, output, 1, sweep data valid.
- out_ready, input, 1, consumer accepts sweep data.
- out_idx, output, N_IN, minterm index being presented.
- out_f, output, 1, mask bit at out_idx.
- done, output, 1, one-cycle pulse at sweep completion.
- ones_count, output, N_IN+1, number of accepted beats with out_f=1 in the last or current sweep.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. All state changes on the rising edge of clk.
- Reset values: mask=RESET_MASK[DEPTH-1:0], f_q=0, state=IDLE, idx=0, busy=0, out_valid=0, out_idx=0, out_f=0, done=0, ones_count=0.
- Reset mid-sweep aborts immediately to these values. No done pulse is produced.
- Direct mode runs in every state: f_q <= mask[in_vec]. Latency is 1 cycle. f_q uses the mask value before any same-edge cfg_we write.
- cfg_we:
  - Accepted only in IDLE and DONE. The new mask is visible to f_q from the next edge.
  - Ignored in SWEEP, so the mask is frozen for the whole sweep.
- FSM states: IDLE, SWEEP, DONE.
  - IDLE: on start=1, go to SWEEP with idx=0 and ones_count=0. start=1 together with cfg_we=1: the mask is written first, and the sweep uses the new mask.
  - SWEEP: out_valid=1, out_idx=idx, out_f=mask[idx], all combinationally from the registered idx.
    - On out_valid&out_ready: ones_count += out_f.
    - If idx==DEPTH-1, go to DONE; otherwise idx++.
    - Without out_ready, out_idx and out_f are held stable.
    - start is ignored.
  - DONE: done=1 and out_valid=0 for exactly one cycle, then go to IDLE.
    - start in DONE is ignored; a new start is required in IDLE.
    - ones_count holds until the next sweep starts.
- Wrap-around: idx never wraps. The terminal beat at DEPTH-1 ends the sweep.
- ones_count maximum is DEPTH, which fits in N_IN+1 bits.
- Minimum sweep length is DEPTH+2 cycles from start: start edge, DEPTH beats, DONE.

Optional Feature:
- Macro: SOP_ABORT_EN.
- With the macro defined:
  - An extra input port abort (1 bit) is added.
  - abort=1 in SWEEP goes to IDLE on the next edge. No done pulse is produced.
  - ones_count keeps the partial count, including a beat accepted on the same edge.
  - abort in IDLE or DONE has no effect.
- Without the macro: no abort port exists, and a sweep always runs to completion.

Decomposition:
- Shared package sop_pkg holds:
  - the state enum (IDLE, SWEEP, DONE);
  - the default N_IN constant;
  - the legacy mask constant SOP_LEGACY_MASK='h35;
  - a depth helper function returning 2^n.
- One natural sub-module, sop_lut_eval: the mask register plus the read mux. It has ports for clk, rst, write enable, write data, and two read addresses (in_vec and idx), and returns both selected bits.
- The FSM, counter and handshake stay in the top level.

Test Plan:
- Reset, then drive in_vec=0..7 one per cycle -> f_q one cycle later reads 1,0,1,0,1,1,0,0 (legacy SoP).
- Pulse start with out_ready=1 constantly -> 8 beats with out_idx 0..7 and out_f 1,0,1,0,1,1,0,0; done pulses on cycle 10 after start; ones_count=4.
- cfg_we with cfg_mask='hFF in IDLE, then sweep with out_ready toggling 1,0,1,0 -> out_idx and out_f held stable across stall cycles; ones_count=8; done once.
- Assert cfg_we with 'h00 and start during SWEEP -> both ignored; the sweep completes with the original mask's values.
- Assert rst at beat 3 of a sweep -> next cycle busy=0, out_valid=0, ones_count=0, mask='h35, no done.
- With SOP_ABORT_EN defined: abort after beats 0..4 accepted -> IDLE with ones_count=3, no done; a following start runs a full sweep normally.
